// File: rtl/divider_core.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered on leaving FINISH and hold until the next done or reset.
module divider_core #(
    parameter int DW    = 24,
    parameter int len_q = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    dividend,
    input  logic [DW-1:0]    divisor,
    output logic             busy,
    output logic             done,
    output logic [len_q-1:0] quotient,
    output logic [DW-1:0]    remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW:0]      rem_q, rem_d;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [len_q-1:0] quo_q, quo_d;
    logic [DW-1:0]    rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [DW+1:0]    shifted;
    logic [DW:0]      diff;
    logic             fits;

    // The dividend register doubles as the quotient: each step shifts its MSB
    // into the partial remainder and the new quotient bit into its LSB.
    always_comb begin
        shifted = {rem_q, dvd_q[DW-1]};
        fits    = (shifted >= {2'b00, dvs_q});
        diff    = shifted[DW:0] - {1'b0, dvs_q};
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE, so a start there must be ignored.
                if (start && !done_q) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    zero_d  = (divisor == '0);
                    rem_d   = '0;
                    cnt_d   = CW'(DW);
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = fits ? diff : shifted[DW:0];
                dvd_d = {dvd_q[DW-2:0], fits};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                quo_d   = zero_q ? '1 : len_q'(dvd_q);
                rmd_d   = rem_q[DW-1:0];
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_core.sv
// Scoreboard bench for divider_core: expected results are queued when an operation
// is issued and popped when done is observed; latency and handshake checked inline.
module tb_divider_core;

    localparam int DW      = 24;
    localparam int LEN_Q   = 24;
    localparam int LAT     = DW + 1;
    localparam int TIMEOUT = 80;

    typedef struct {
        logic [LEN_Q-1:0] q;
        logic [DW-1:0]    r;
        logic             z;
    } result_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [DW-1:0]    dividend;
    logic [DW-1:0]    divisor;
    logic             busy;
    logic             done;
    logic [LEN_Q-1:0] quotient;
    logic [DW-1:0]    remainder;
    logic             div_by_zero;

    result_t sb_q[$];
    int      pass_cnt;
    int      total_cnt;

    // Values captured by run_op for the calling test to compare.
    int               obs_lat;
    int               obs_busy;
    logic [LEN_Q-1:0] obs_q;
    logic [DW-1:0]    obs_r;
    logic             obs_z;
    logic [LEN_Q-1:0] obs_q_at_start;

    divider_core #(.DW(DW), .len_q(LEN_Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expected(input logic [DW-1:0] a, input logic [DW-1:0] b);
        result_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = LEN_Q'(a / b);
            e.r = a % b;
            e.z = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    // Issue one operation; glitch > 0 pulses start with other operands at that cycle.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int glitch);
        push_expected(a, b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start          = 1'b0;
        obs_q_at_start = quotient;
        obs_busy       = busy ? 1 : 0;
        obs_lat        = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                obs_lat = k;
                break;
            end
            if (busy) obs_busy++;
            if (k == glitch) begin
                start    = 1'b1;
                dividend = 24'd9;
                divisor  = 24'd3;
            end else if (k == glitch + 1) begin
                start    = 1'b0;
                dividend = 24'h00ABCD;
                divisor  = 24'd5;
            end
        end
        obs_q = quotient;
        obs_r = remainder;
        obs_z = div_by_zero;
    endtask

    task automatic check_result(input string name);
        result_t e;
        if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        total_cnt++;
        if (obs_lat !== LAT) $display("FAIL %s latency: got %0d want %0d", name, obs_lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (obs_q !== e.q) $display("FAIL %s quotient: got %0d want %0d", name, obs_q, e.q);
        else pass_cnt++;
        total_cnt++;
        if (obs_r !== e.r) $display("FAIL %s remainder: got %0d want %0d", name, obs_r, e.r);
        else pass_cnt++;
        total_cnt++;
        if (obs_z !== e.z) $display("FAIL %s div_by_zero: got %0b want %0b", name, obs_z, e.z);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        total_cnt++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0)
            $display("FAIL reset outputs: got b%0b d%0b q%0d r%0d z%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(24'd100, 24'd3, 0);
        check_result("100/3");
        total_cnt++;
        if (obs_busy !== DW) $display("FAIL busy_cycles: got %0d want %0d", obs_busy, DW);
        else pass_cnt++;
        // Results must hold after the done pulse.
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got %0b want 0", done);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (quotient !== 24'd33 || remainder !== 24'd1)
            $display("FAIL hold_100/3: got q%0d r%0d want q33 r1", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_op(24'd144, 24'd12, 0);
        check_result("144/12");
        run_op(24'd123456, 24'd789, 0);
        check_result("123456/789");
        total_cnt++;
        if (obs_q_at_start !== 24'd12)
            $display("FAIL not_cleared_on_start: got %0d want 12", obs_q_at_start);
        else pass_cnt++;
        // A start raised in the done cycle is ignored.
        start    = 1'b1;
        dividend = 24'd77;
        divisor  = 24'd7;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL start_in_done_cycle: busy got %0b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        run_op(24'd2023, 24'd1, 0);
        check_result("2023/1");
        run_op(24'hFFFFFF, 24'd1, 0);
        check_result("16777215/1");
        run_op(24'd5, 24'd9, 0);
        check_result("5/9");
        run_op(24'd0, 24'd17, 0);
        check_result("0/17");
        run_op(24'hFFFFFF, 24'hFFFFFF, 0);
        check_result("max/max");
        for (int i = 0; i < 6; i++) begin
            run_op(DW'($urandom_range(24'hFFFFFF, 0)), DW'($urandom_range(24'hFFF, 1)), 0);
            check_result("random");
        end
    endtask

    task automatic test_div_zero();
        run_op(24'd100, 24'd0, 0);
        check_result("100/0");
        total_cnt++;
        if (obs_q !== 24'hFFFFFF) $display("FAIL dbz_quotient: got %h want ffffff", obs_q);
        else pass_cnt++;
        run_op(24'd10, 24'd2, 0);
        check_result("10/2_after_dbz");
    endtask

    task automatic test_ignore_start();
        run_op(24'd1000, 24'd7, 5);
        check_result("1000/7_ignore");
    endtask

    task automatic test_reset_mid();
        push_expected(24'd50000, 24'd13);
        @(negedge clk);
        start    = 1'b1;
        dividend = 24'd50000;
        divisor  = 24'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0)
            $display("FAIL async_reset_outputs: got b%0b d%0b q%0d r%0d z%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        else pass_cnt++;
        // Aborted operation yields no result.
        void'(sb_q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_lat = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) obs_lat++;
        end
        total_cnt++;
        if (obs_lat !== 0) $display("FAIL no_done_after_reset: active cycles got %0d want 0", obs_lat);
        else pass_cnt++;
        run_op(24'd50000, 24'd13, 0);
        check_result("50000/13_after_reset");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
